// File: rtl/conv_encoder_param.sv
// Rate-1/2 convolutional encoder with a parametrised constraint length and generators.
// A frame of FRAME_W bits is taken in parallel and streamed out MSB first as one
// {c1,c0} symbol per output handshake. The mode is chosen per frame:
//   - zero-tail flush: K-1 extra symbols with u=0 follow the data.
//   - tail-biting: the encoder state is preloaded with the last K-1 info bits.
//
// Handshake rule (both sides): a transfer happens on a rising clock edge where
// valid and ready are both high. A producer holding valid keeps its payload
// stable until that edge. in_ready never depends on in_valid.
module conv_encoder_param #(
    parameter int             FRAME_W = 8,
    parameter int             K       = 5,
    parameter logic [K-1:0]   G0      = 5'b11111,
    parameter logic [K-1:0]   G1      = 5'b11011
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [FRAME_W-1:0] in_data,
    input  logic               tail_bite,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [1:0]         out_sym,
    output logic               out_last,
    output logic               frame_done,
    output logic [1:0]         dbg_state,
    output logic [K-2:0]       dbg_sreg
);

    localparam int CW = $clog2(FRAME_W + K);

    // Out-of-range parameters stop elaboration.
    if (K < 3 || K > 9 || FRAME_W < K) begin : g_bad_params
        $fatal(1, "conv_encoder_param: illegal parameters FRAME_W=%0d K=%0d", FRAME_W, K);
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ENC  = 2'd1,
        TAIL = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [K-2:0]       s_reg;      // encoder state after the last transferred bit
    logic [FRAME_W-1:0] frame_sr;   // remaining info bits, current bit at the MSB
    logic               mode_tb;    // latched tail_bite
    logic [CW-1:0]      cnt;        // symbols already transferred in this frame

    logic               hs;
    logic               accept;
    logic               u_cur;
    logic [K-2:0]       s_next;
    logic [FRAME_W-1:0] sr_next;
    logic [1:0]         sym_next;
    logic [CW-1:0]      last_idx;
    logic               last_next;
    logic [K-2:0]       s_init;
    logic [1:0]         sym_init;

    // Window is {S, u}: bit 0 is the new bit, bit j is S[j-1].
    function automatic logic [1:0] encode(input logic [K-2:0] s, input logic u);
        logic [K-1:0] w;
        w = {s, u};
        return {^(w & G1), ^(w & G0)};
    endfunction

    assign dbg_state = state_q;
    assign dbg_sreg  = s_reg;

    // Datapath helpers: next symbol after a transfer, and the first symbol of a new frame.
    // Zeros shift into frame_sr, so the tail bits of a flushed frame come out as u=0.
    always_comb begin
        hs        = out_valid & out_ready;
        accept    = in_valid & in_ready;
        u_cur     = frame_sr[FRAME_W-1];
        s_next    = {s_reg[K-3:0], u_cur};
        sr_next   = {frame_sr[FRAME_W-2:0], 1'b0};
        sym_next  = encode(s_next, sr_next[FRAME_W-1]);
        last_idx  = mode_tb ? CW'(FRAME_W - 1) : CW'(FRAME_W + K - 2);
        last_next = ((cnt + CW'(1)) == last_idx);
        s_init    = tail_bite ? in_data[K-2:0] : '0;
        sym_init  = encode(s_init, in_data[FRAME_W-1]);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and in_ready.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = ENC;
                end
            end
            ENC: begin
                if (hs && cnt == CW'(FRAME_W - 1)) begin
                    state_d = mode_tb ? IDLE : TAIL;
                end
            end
            TAIL: begin
                if (hs && out_last) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Frame load, per-symbol advance and registered output symbol.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_reg      <= '0;
            frame_sr   <= '0;
            mode_tb    <= 1'b0;
            cnt        <= '0;
            out_valid  <= 1'b0;
            out_sym    <= 2'b00;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (accept) begin
                mode_tb   <= tail_bite;
                s_reg     <= s_init;
                frame_sr  <= in_data;
                cnt       <= '0;
                out_sym   <= sym_init;
                out_valid <= 1'b1;
                out_last  <= 1'b0;
            end else if (hs) begin
                s_reg    <= s_next;
                frame_sr <= sr_next;
                cnt      <= cnt + CW'(1);
                if (out_last) begin
                    out_valid  <= 1'b0;
                    out_last   <= 1'b0;
                    out_sym    <= 2'b00;
                    frame_done <= 1'b1;
                end else begin
                    out_sym  <= sym_next;
                    out_last <= last_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_encoder_param.sv
// Directed bench for conv_encoder_param (FRAME_W=8, K=5, G0=11111, G1=11011).
// Expected symbol streams are hand-derived with c0=u^S0^S1^S2^S3, c1=u^S0^S2^S3.
module tb_conv_encoder_param;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       tail_bite;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_sym;
    logic       out_last;
    logic       frame_done;
    logic [1:0] dbg_state;
    logic [3:0] dbg_sreg;

    int n_vec;
    int n_err;
    logic [1:0] exp_q[$];

    conv_encoder_param dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .tail_bite  (tail_bite),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sym    (out_sym),
        .out_last   (out_last),
        .frame_done (frame_done),
        .dbg_state  (dbg_state),
        .dbg_sreg   (dbg_sreg)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected streams.
    task automatic load_flush_80();
        logic [1:0] seq [12] = '{2'd3, 2'd3, 2'd1, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
        exp_q.delete();
        foreach (seq[i]) exp_q.push_back(seq[i]);
    endtask

    task automatic load_flush_00();
        exp_q.delete();
        for (int i = 0; i < 12; i++) exp_q.push_back(2'd0);
    endtask

    task automatic load_tb_01();
        logic [1:0] seq [8] = '{2'd3, 2'd1, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd3};
        exp_q.delete();
        foreach (seq[i]) exp_q.push_back(seq[i]);
    endtask

    // Offer a frame at the current sample point; returns #1 after the accept edge.
    task automatic send_frame(input logic [7:0] data, input logic tb, input logic keep_valid);
        in_valid  = 1'b1;
        in_data   = data;
        tail_bite = tb;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL accept_ready: in_ready=%b required 1", in_ready);
        end
        @(posedge clk); #1;
        if (!keep_valid) in_valid = 1'b0;
        n_vec++;
        if (out_valid !== 1'b1 || dbg_state !== 2'd1) begin
            n_err++;
            $display("FAIL first_latency: out_valid=%b state=%0d required 1/1", out_valid, dbg_state);
        end
    endtask

    // Consume exp_q symbol by symbol, then check the frame-end cycle.
    task automatic drain(input int stall_pct, input int hold_last, input string name);
        logic [1:0] exp_sym;
        logic [1:0] prev_sym;
        logic       prev_last;
        logic       prev_stall;
        logic       exp_last;
        int         budget;
        int         hold_cnt;
        prev_stall = 1'b0;
        prev_sym   = 2'b00;
        prev_last  = 1'b0;
        budget     = 0;
        hold_cnt   = 0;
        while (exp_q.size() != 0 && budget < 2000) begin
            if (out_valid && out_last && hold_cnt < hold_last) begin
                out_ready = 1'b0;
                hold_cnt++;
            end else if (stall_pct > 0) begin
                out_ready = ($urandom_range(0, 99) >= stall_pct);
            end else begin
                out_ready = 1'b1;
            end
            if (prev_stall) begin
                n_vec++;
                if (out_valid !== 1'b1 || out_sym !== prev_sym || out_last !== prev_last) begin
                    n_err++;
                    $display("FAIL %s stall_hold: valid=%b sym=%b last=%b required 1/%b/%b",
                             name, out_valid, out_sym, out_last, prev_sym, prev_last);
                end
            end
            n_vec++;
            if (frame_done !== 1'b0 || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL %s busy_flags: frame_done=%b in_ready=%b required 0/0",
                         name, frame_done, in_ready);
            end
            if (out_valid && out_ready) begin
                exp_sym  = exp_q.pop_front();
                exp_last = (exp_q.size() == 0);
                n_vec++;
                if (out_sym !== exp_sym) begin
                    n_err++;
                    $display("FAIL %s sym: got %b required %b (remaining %0d)",
                             name, out_sym, exp_sym, exp_q.size());
                end
                n_vec++;
                if (out_last !== exp_last) begin
                    n_err++;
                    $display("FAIL %s last: got %b required %b (remaining %0d)",
                             name, out_last, exp_last, exp_q.size());
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_sym   = out_sym;
            prev_last  = out_last;
            @(posedge clk); #1;
            budget++;
        end
        out_ready = 1'b1;
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s timeout: %0d symbols missing, required 0", name, exp_q.size());
            exp_q.delete();
        end
        n_vec++;
        if (frame_done !== 1'b1 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL %s frame_end: done=%b in_ready=%b valid=%b required 1/1/0",
                     name, frame_done, in_ready, out_valid);
        end
    endtask

    task automatic check_sreg(input logic [3:0] exp_s, input string name);
        n_vec++;
        if (dbg_sreg !== exp_s) begin
            n_err++;
            $display("FAIL %s final_s: got %b required %b", name, dbg_sreg, exp_s);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        tail_bite = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sym !== 2'b00 || out_last !== 1'b0 ||
            frame_done !== 1'b0 || dbg_sreg !== 4'b0000 || dbg_state !== 2'd0) begin
            n_err++;
            $display("FAIL reset_values: rdy=%b vld=%b sym=%b last=%b done=%b s=%b st=%0d required 1/0/00/0/0/0000/0",
                     in_ready, out_valid, out_sym, out_last, frame_done, dbg_sreg, dbg_state);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_flush_80();
        load_flush_80();
        send_frame(8'h80, 1'b0, 1'b0);
        drain(0, 0, "flush_80");
        check_sreg(4'b0000, "flush_80");
        @(posedge clk); #1;
        n_vec++;
        if (frame_done !== 1'b0) begin
            n_err++;
            $display("FAIL flush_80 done_pulse: frame_done=%b required 0", frame_done);
        end
    endtask

    task automatic test_flush_00();
        load_flush_00();
        send_frame(8'h00, 1'b0, 1'b0);
        drain(0, 0, "flush_00");
        check_sreg(4'b0000, "flush_00");
        @(posedge clk); #1;
    endtask

    task automatic test_tail_bite();
        load_tb_01();
        send_frame(8'h01, 1'b1, 1'b0);
        drain(0, 0, "tailbite_01");
        check_sreg(4'b0001, "tailbite_01");
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        load_flush_80();
        send_frame(8'h80, 1'b0, 1'b0);
        drain(40, 5, "stall_80");
        check_sreg(4'b0000, "stall_80");
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_frame();
        logic [1:0] seq [3] = '{2'd3, 2'd3, 2'd1};
        send_frame(8'h80, 1'b0, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (out_valid !== 1'b1 || out_sym !== seq[i]) begin
                n_err++;
                $display("FAIL midreset_pre sym%0d: valid=%b sym=%b required 1/%b", i, out_valid, out_sym, seq[i]);
            end
            @(posedge clk); #1;
        end
        reset = 1'b1;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_last !== 1'b0 || out_sym !== 2'b00 ||
            dbg_sreg !== 4'b0000) begin
            n_err++;
            $display("FAIL midreset_async: vld=%b rdy=%b last=%b sym=%b s=%b required 0/1/0/00/0000",
                     out_valid, in_ready, out_last, out_sym, dbg_sreg);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (frame_done !== 1'b0 || out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL midreset_quiet: done=%b valid=%b required 0/0", frame_done, out_valid);
            end
            @(posedge clk); #1;
        end
        load_flush_80();
        send_frame(8'h80, 1'b0, 1'b0);
        drain(0, 0, "midreset_rerun");
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        load_flush_80();
        send_frame(8'h80, 1'b0, 1'b1);
        // The next frame's contents appear while the first is still streaming.
        in_data   = 8'h01;
        tail_bite = 1'b1;
        drain(0, 0, "b2b_first");
        // in_valid is still high here, so the accept happens at the coming edge.
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_vec++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_accept: valid=%b in_ready=%b required 1/0", out_valid, in_ready);
        end
        load_tb_01();
        drain(0, 0, "b2b_second");
        check_sreg(4'b0001, "b2b_second");
        @(posedge clk); #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_flush_80();
        test_flush_00();
        test_tail_bite();
        test_backpressure();
        test_reset_mid_frame();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
